// File: rtl/uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// uart_rx_monitor
//
// 8N1 asynchronous serial receiver placed on the ACIA txd pin. It recovers
// frames on the system clock, hands each byte to a consumer through a
// valid/ready holding register, and flags framing errors, overruns and line
// breaks.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high
//   rxd_in       asynchronous serial line, idle high
//   rx_data      received byte, stable while rx_valid=1
//   rx_valid     byte available, held until accepted
//   rx_ready     consumer accepts rx_data when rx_valid && rx_ready
//   framing_err  one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: good byte lost because holding reg was full
//   break_det    level, high while the line is in break
//   busy         high whenever the receiver is not idle
//
// Handshake: a transfer happens on every rising clock edge where
// rx_valid && rx_ready. rx_valid then drops on the next cycle unless a new
// byte is committed on that same edge, in which case it stays high and
// rx_data moves to the new byte. While rx_valid=1 and no transfer happens,
// rx_data holds its value.
// ---------------------------------------------------------------------------
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       break_det,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q;
  logic        rx_s_q;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        commit_q, commit_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        framing_q, framing_d;
  logic        overrun_q, overrun_d;

  // Frame FSM next state. The timer free-runs inside a bit and is cleared at
  // every sample point, so each compare is a simple equality.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 16'd1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    commit_d  = 1'b0;
    framing_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (rx_s_q) begin
            // Line went back high before mid start bit: a glitch.
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d         = '0;
          shift_d[idx_q]  = rx_s_q;
          idx_d           = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s_q) begin
            // Back to IDLE immediately so a start bit half a stop bit later
            // is still caught.
            commit_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            framing_d = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A low line here is the break itself, never a new start bit.
        timer_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register. The commit lands one cycle after the stop sample.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (commit_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      commit_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      framing_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= rxd_in;
      rx_s_q     <= sync1_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      commit_q   <= commit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      framing_q  <= framing_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_q;
  assign overrun     = overrun_q;
  assign break_det   = (state_q == S_BREAK);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_monitor
//
// Directed bench for uart_rx_monitor at the default 87 clk/bit. A negedge
// monitor logs every accepted byte against exp_q and counts flag pulses;
// the main sequence drives frames and checks timing and levels.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_monitor;

  localparam int CPB  = 87;
  localparam int HALF = CPB / 2;

  // ---- clock / reset -------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun;
  logic       break_det;
  logic       busy;

  always #50 clk = ~clk;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd_in      (rxd_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .break_det   (break_det),
    .busy        (busy)
  );

  // ---- scoreboard ----------------------------------------------------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int frm_cnt = 0;
  int ovr_cnt = 0;
  int acc_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        acc_cnt++;
        check_eq("acc_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("acc_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (framing_err) frm_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  // ---- driver tasks --------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    rxd_in = v;
    wait_clk(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
    rxd_in = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_valid"}, 32'(rx_valid), 32'd0);
    check_eq({pfx, "_data"},  32'(rx_data), 32'h00);
    check_eq({pfx, "_busy"},  32'(busy), 32'd0);
    check_eq({pfx, "_brk"},   32'(break_det), 32'd0);
    check_eq({pfx, "_frm"},   32'(framing_err), 32'd0);
    check_eq({pfx, "_ovr"},   32'(overrun), 32'd0);
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---- main sequence -------------------------------------------------------
  initial begin
    int lat;
    int f0;
    int o0;
    int a0;

    wait_clk(3);
    check_reset_outputs("rst0");
    reset = 1'b0;
    wait_clk(10);

    // 0x41 with consumer always ready: one-cycle valid, 830 cycles after fall.
    exp_q.push_back(8'h41);
    rx_ready = 1'b1;
    f0 = frm_cnt;
    o0 = ovr_cnt;
    fork
      send_byte(8'h41, 1'b1);
      begin
        lat = 0;
        for (int c = 1; c <= 1000; c++) begin
          wait_clk(1);
          if (rx_valid) begin
            lat = c;
            break;
          end
        end
        check_eq("t1_latency", 32'(lat), 32'd830);
        check_eq("t1_data", 32'(rx_data), 32'h41);
        wait_clk(1);
        check_eq("t1_valid_fall", 32'(rx_valid), 32'd0);
      end
    join
    check_eq("t1_no_frm", 32'(frm_cnt - f0), 32'd0);
    check_eq("t1_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    rx_ready = 1'b0;
    wait_clk(50);

    // 0x55 then 0xAA back-to-back, never accepted: second byte overruns.
    o0 = ovr_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    wait_clk(5);
    check_eq("t2_ovr_once", 32'(ovr_cnt - o0), 32'd1);
    check_eq("t2_valid", 32'(rx_valid), 32'd1);
    check_eq("t2_data_held", 32'(rx_data), 32'h55);
    exp_q.push_back(8'h55);
    rx_ready = 1'b1;
    wait_clk(1);
    check_eq("t2_valid_fall", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;
    wait_clk(50);

    // 20-cycle glitch: rejected at mid start bit, nothing reported.
    f0 = frm_cnt;
    o0 = ovr_cnt;
    rxd_in = 1'b0;
    wait_clk(20);
    rxd_in = 1'b1;
    wait_clk(HALF + 1 - 20);
    check_eq("t3_busy_during", 32'(busy), 32'd1);
    wait_clk(2);
    check_eq("t3_busy_cleared", 32'(busy), 32'd0);
    wait_clk(900);
    check_eq("t3_no_valid", 32'(rx_valid), 32'd0);
    check_eq("t3_no_flags", 32'((frm_cnt - f0) + (ovr_cnt - o0)), 32'd0);

    // 0x00 with low stop bit and a held-low line: framing error then break.
    f0 = frm_cnt;
    send_byte(8'h00, 1'b0);
    rxd_in = 1'b0;
    wait_clk(2000);
    check_eq("t4_frm_once", 32'(frm_cnt - f0), 32'd1);
    check_eq("t4_brk_high", 32'(break_det), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd1);
    rxd_in = 1'b1;
    wait_clk(2);
    check_eq("t4_brk_still", 32'(break_det), 32'd1);
    wait_clk(2);
    check_eq("t4_brk_clear", 32'(break_det), 32'd0);
    check_eq("t4_no_valid", 32'(rx_valid), 32'd0);
    wait_clk(50);

    // Pending 0x12 accepted on the exact cycle 0x34 commits.
    o0 = ovr_cnt;
    send_byte(8'h12, 1'b1);
    check_eq("t5_first_valid", 32'(rx_valid), 32'd1);
    check_eq("t5_first_data", 32'(rx_data), 32'h12);
    wait_clk(30);
    exp_q.push_back(8'h12);
    fork
      send_byte(8'h34, 1'b1);
      begin
        wait_clk(829);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        check_eq("t5_valid_kept", 32'(rx_valid), 32'd1);
        check_eq("t5_new_data", 32'(rx_data), 32'h34);
      end
    join
    wait_clk(5);
    check_eq("t5_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    check_eq("t5_data_stable", 32'(rx_data), 32'h34);

    // Reset mid-frame (bit 4 of 0xC3) with 0x34 still held.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rxd_in = 1'b0;
    wait_clk(40);
    reset = 1'b1;
    rxd_in = 1'b1;
    wait_clk(1);
    check_reset_outputs("t6_rst");
    wait_clk(2);
    reset = 1'b0;
    wait_clk(100);
    check_eq("t6_idle_after", 32'(busy), 32'd0);
    a0 = acc_cnt;
    exp_q.push_back(8'h7E);
    rx_ready = 1'b1;
    send_byte(8'h7E, 1'b1);
    wait_clk(20);
    check_eq("t6_one_byte", 32'(acc_cnt - a0), 32'd1);
    rx_ready = 1'b0;

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
